// File: rtl/wb_rr_arbiter.sv
// N-master to 1-slave classic Wishbone arbiter with round-robin grants held for the whole CYC.
// Latency: one cycle from request to grant; data/strobes then pass combinationally both ways.
// Backpressure: losers simply wait with STB high; a stalled slave is cut off by the watchdog via ERR.
module wb_rr_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_MASTERS-1:0]              m_cyc_i,
  input  logic [NUM_MASTERS-1:0]              m_stb_i,
  input  logic [NUM_MASTERS-1:0]              m_we_i,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_sel_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_addr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_data_i,
  output logic [DATA_WIDTH-1:0]               m_data_o,
  output logic [NUM_MASTERS-1:0]              m_ack_o,
  output logic [NUM_MASTERS-1:0]              m_err_o,
  output logic                                s_cyc_o,
  output logic                                s_stb_o,
  output logic                                s_we_o,
  output logic [DATA_WIDTH/8-1:0]             s_sel_o,
  output logic [ADDR_WIDTH-1:0]               s_addr_o,
  output logic [DATA_WIDTH-1:0]               s_data_o,
  input  logic [DATA_WIDTH-1:0]               s_data_i,
  input  logic                                s_ack_i,
  output logic [NUM_MASTERS-1:0]              grant_o,
  output logic                                timeout_o
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_WIDTH = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int WD_WIDTH  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

  state_t                 state;
  logic [NUM_MASTERS-1:0] grant;
  // last_grant doubles as the owner index while BUSY
  logic [IDX_WIDTH-1:0]   last_grant;
  logic [WD_WIDTH-1:0]    wd_cnt;

  logic [NUM_MASTERS-1:0] req;
  logic [IDX_WIDTH-1:0]   pick;
  int                     cand;
  logic                   owner_cyc;
  logic                   owner_stb;
  logic                   fire;

  // Round-robin pick: first requester after last_grant, wrapping; the nearest candidate is assigned last
  always_comb begin
    req  = m_cyc_i & m_stb_i;
    pick = last_grant;
    cand = 0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      cand = (int'(last_grant) + i) % NUM_MASTERS;
      if (req[cand[IDX_WIDTH-1:0]]) pick = cand[IDX_WIDTH-1:0];
    end
  end

  // Owner view of the bus; the watchdog fires on the last stalled cycle unless ACK arrives in it
  always_comb begin
    owner_cyc = (state == BUSY) && m_cyc_i[last_grant];
    owner_stb = owner_cyc && m_stb_i[last_grant];
    fire      = (TIMEOUT_CYCLES != 0) && owner_stb && !s_ack_i &&
                (wd_cnt == WD_WIDTH'(TIMEOUT_CYCLES - 1));
  end

  assign s_cyc_o   = owner_cyc;
  assign s_stb_o   = owner_stb;
  assign s_we_o    = m_we_i[last_grant];
  assign s_sel_o   = m_sel_i[last_grant*SEL_WIDTH +: SEL_WIDTH];
  assign s_addr_o  = m_addr_i[last_grant*ADDR_WIDTH +: ADDR_WIDTH];
  assign s_data_o  = m_data_i[last_grant*DATA_WIDTH +: DATA_WIDTH];
  assign m_data_o  = s_data_i;
  assign m_ack_o   = grant & {NUM_MASTERS{s_ack_i & owner_cyc}};
  assign m_err_o   = grant & {NUM_MASTERS{fire}};
  assign timeout_o = fire;
  assign grant_o   = grant;

  // Arbitration FSM: grant in IDLE, hold through CYC in BUSY, one dead cycle in ABORT after a timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= IDX_WIDTH'(NUM_MASTERS - 1);
      wd_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (|req) begin
            grant      <= {{(NUM_MASTERS-1){1'b0}}, 1'b1} << pick;
            last_grant <= pick;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (!m_cyc_i[last_grant]) begin
            state  <= IDLE;
            grant  <= '0;
            wd_cnt <= '0;
          end else if (fire) begin
            state  <= ABORT;
            grant  <= '0;
            wd_cnt <= '0;
          end else if (owner_stb && !s_ack_i) begin
            wd_cnt <= wd_cnt + 1'b1;
          end else begin
            wd_cnt <= '0;
          end
        end
        ABORT: begin
          state  <= IDLE;
          wd_cnt <= '0;
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: directed Wishbone scenarios plus randomized request mixes.
// Expected grants come from an index-based round-robin model over the pending-request set.
// Slave responses (delay, read data) are generated here; timeouts are predicted from the stall count.
module tb_wb_rr_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      m_cyc_i, m_stb_i, m_we_i;
  logic [N*SW-1:0]   m_sel_i;
  logic [N*AW-1:0]   m_addr_i;
  logic [N*DW-1:0]   m_data_i;
  logic [DW-1:0]     m_data_o;
  logic [N-1:0]      m_ack_o, m_err_o, grant_o;
  logic              s_cyc_o, s_stb_o, s_we_o, s_ack_i, timeout_o;
  logic [SW-1:0]     s_sel_o;
  logic [AW-1:0]     s_addr_o;
  logic [DW-1:0]     s_data_o, s_data_i;

  wb_rr_arbiter #(
    .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_sel_i(m_sel_i),
    .m_addr_i(m_addr_i), .m_data_i(m_data_i), .m_data_o(m_data_o),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state: pending requesters, last winner, and each master's current transfer
  logic [N-1:0]    pend;
  int              last_w;
  logic            ex_we[N];
  logic [SW-1:0]   ex_sel[N];
  logic [AW-1:0]   ex_addr[N];
  logic [DW-1:0]   ex_data[N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_next(input logic [N-1:0] mask, input int last);
    for (int k = 1; k <= N; k++) begin
      if (mask[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic drive(input int w);
    m_we_i[w]            = ex_we[w];
    m_sel_i[w*SW +: SW]  = ex_sel[w];
    m_addr_i[w*AW +: AW] = ex_addr[w];
    m_data_i[w*DW +: DW] = ex_data[w];
  endtask

  task automatic raise(input int w);
    ex_we[w]   = 1'($urandom_range(0, 1));
    ex_sel[w]  = SW'($urandom_range(1, 15));
    ex_addr[w] = $urandom;
    ex_data[w] = $urandom;
    drive(w);
    m_cyc_i[w] = 1'b1;
    m_stb_i[w] = 1'b1;
    pend[w]    = 1'b1;
  endtask

  task automatic drop(input int w);
    m_cyc_i[w] = 1'b0;
    m_stb_i[w] = 1'b0;
    pend[w]    = 1'b0;
  endtask

  // Entered in an IDLE cycle (edge+1) with requests driven; runs one granted cycle to completion
  task automatic serve(input int dly, input int beats, input bit rereq,
                       input bit use_fixed, input logic [DW-1:0] fixed_rd);
    int w, c, beat;
    logic [N-1:0] oh;
    logic [DW-1:0] rd;
    bit exp_err, fin;
    w  = rr_next(pend, last_w);
    oh = N'(1) << w;
    #1;
    check("idle_grant", 64'(grant_o), 64'(0));
    check("idle_cyc", 64'(s_cyc_o), 64'(0));
    tick();
    c = 0; beat = 0; fin = 0; exp_err = 0;
    while (!fin) begin
      rd       = use_fixed ? fixed_rd : DW'($urandom);
      s_data_i = rd;
      s_ack_i  = (c == dly);
      exp_err  = (c == TO - 1) && !s_ack_i;
      #1;
      check("grant", 64'(grant_o), 64'(oh));
      check("s_cyc", 64'(s_cyc_o), 64'(1));
      check("s_stb", 64'(s_stb_o), 64'(1));
      check("s_addr", 64'(s_addr_o), 64'(ex_addr[w]));
      check("s_wdata", 64'(s_data_o), 64'(ex_data[w]));
      check("s_we", 64'(s_we_o), 64'(ex_we[w]));
      check("s_sel", 64'(s_sel_o), 64'(ex_sel[w]));
      check("m_ack", 64'(m_ack_o), s_ack_i ? 64'(oh) : 64'(0));
      check("m_err", 64'(m_err_o), exp_err ? 64'(oh) : 64'(0));
      check("timeout", 64'(timeout_o), 64'(exp_err));
      if (s_ack_i) begin
        check("rdata", 64'(m_data_o), 64'(rd));
        beat++;
        if (beat == beats) begin
          fin = 1;
        end else begin
          tick();
          s_ack_i    = 1'b0;
          ex_addr[w] = $urandom;
          ex_data[w] = $urandom;
          drive(w);
          c = 0;
        end
      end else if (exp_err) begin
        fin = 1;
      end else begin
        tick();
        c++;
      end
    end
    // Owner still holds CYC here: ABORT must mask it, a normal end still shows it
    tick();
    s_ack_i = 1'b0;
    #1;
    check("post_cyc", 64'(s_cyc_o), exp_err ? 64'(0) : 64'(1));
    check("post_grant", 64'(grant_o), exp_err ? 64'(0) : 64'(oh));
    check("post_err", 64'(m_err_o | N'(timeout_o)), 64'(0));
    drop(w);
    #1;
    check("drop_cyc", 64'(s_cyc_o), 64'(0));
    last_w = w;
    tick();
    if (rereq) raise(w);
  endtask

  initial begin
    int budget;
    rst      = 1'b1;
    m_cyc_i  = '1; m_stb_i = '1; m_we_i = '0;
    m_sel_i  = '0; m_addr_i = '0; m_data_i = '0;
    s_data_i = '0; s_ack_i = 1'b1;
    pend     = '0;
    last_w   = N - 1;
    #3;
    check("rst_cyc", 64'(s_cyc_o), 64'(0));
    check("rst_stb", 64'(s_stb_o), 64'(0));
    check("rst_ack", 64'(m_ack_o), 64'(0));
    check("rst_err", 64'(m_err_o), 64'(0));
    check("rst_grant", 64'(grant_o), 64'(0));
    check("rst_timeout", 64'(timeout_o), 64'(0));
    m_cyc_i = '0; m_stb_i = '0; s_ack_i = 1'b0;
    @(posedge clk); #3; rst = 1'b0;
    tick();

    // Single master read, slave answers two cycles after STB
    ex_we[0] = 1'b0; ex_sel[0] = 4'hF; ex_addr[0] = 32'h0000_0010; ex_data[0] = '0;
    drive(0); m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1; pend[0] = 1'b1;
    serve(2, 1, 1'b0, 1'b1, 32'hDEAD_BEEF);

    // Fairness: all masters keep re-requesting one-beat cycles
    raise(0); raise(1); raise(2);
    for (int i = 0; i < 6; i++) serve(0, 1, 1'b1, 1'b0, '0);
    while (pend != 0) serve(1, 1, 1'b0, 1'b0, '0);

    // Locked burst: master 0 goes first so master 1 wins the contended round
    raise(0);
    serve(0, 1, 1'b0, 1'b0, '0);
    raise(0); raise(1);
    serve(1, 4, 1'b0, 1'b0, '0);
    serve(0, 1, 1'b0, 1'b0, '0);

    // Watchdog: silent slave, then the other pending master must follow
    raise(2); raise(0);
    serve(99, 1, 1'b0, 1'b0, '0);
    serve(0, 1, 1'b0, 1'b0, '0);

    // ACK in the last watchdog cycle wins
    raise(1);
    serve(TO - 1, 1, 1'b0, 1'b0, '0);

    // Randomized request mixes
    budget = 20;
    for (int r = 0; r < 30; r++) begin
      for (int k = 0; k < N; k++) if ($urandom_range(0, 1) == 1) raise(k);
      if (pend == 0) raise(int'($urandom_range(0, N - 1)));
      while (pend != 0) begin
        int d, pick_d;
        bit rq;
        pick_d = int'($urandom_range(0, 5));
        d  = (pick_d == 4) ? TO - 1 : (pick_d == 5) ? 99 : pick_d;
        rq = (budget > 0) && ($urandom_range(0, 2) == 0);
        if (rq) budget--;
        serve(d, int'($urandom_range(1, 3)), rq, 1'b0, '0);
      end
    end

    // Reset in the middle of a strobed transfer
    raise(2);
    #1;
    tick();
    s_ack_i = 1'b1;
    #1;
    check("pre_rst_grant", 64'(grant_o), 64'(3'b100));
    #2; rst = 1'b1; #1;
    check("mid_rst_cyc", 64'(s_cyc_o), 64'(0));
    check("mid_rst_stb", 64'(s_stb_o), 64'(0));
    check("mid_rst_ack", 64'(m_ack_o), 64'(0));
    check("mid_rst_grant", 64'(grant_o), 64'(0));
    s_ack_i = 1'b0;
    drop(2);
    #1; rst = 1'b0;
    last_w = N - 1;
    tick();
    raise(0); raise(1); raise(2);
    while (pend != 0) serve(0, 1, 1'b0, 1'b0, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time bound so a wedged run still terminates
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
